// File: rtl/serial_add_pkg.sv
// Shared types for the serial word adder.
// State encoding and overflow-mode selectors.
package serial_add_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } sa_state_t;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;

endpackage

// File: rtl/serial_word_adder_ovf_stat.sv
// Saturating overflow counter with a sticky alarm.
// A clear in the same cycle as an increment drops the increment.
module ovf_stat_counter #(
  parameter int CNT_W        = 4,
  parameter int ALARM_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             alarm_o
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(ALARM_THRESH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             alarm_q, alarm_d;

  always_comb begin
    count_d = count_q;
    alarm_d = alarm_q;
    if (clr_i) begin
      count_d = '0;
      alarm_d = 1'b0;
    end else begin
      if (inc_i && count_q != MAX)
        count_d = count_q + 1'b1;
      alarm_d = alarm_q | (count_d >= THR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      count_q <= count_d;
      alarm_q <= alarm_d;
    end
  end

  assign count_o = count_q;
  assign alarm_o = alarm_q;

endmodule

// File: rtl/serial_word_adder.sv
// LSB-first serial adder over two lines with word framing,
// overflow detection and overflow statistics.
module serial_word_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SIGNED_MODE  = MODE_UNSIGNED,
  parameter int CNT_W        = 4,
  parameter int ALARM_THRESH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             start,
  input  logic             line1,
  input  logic             line2,
  input  logic             clear_stat,
  output logic             outp,
  output logic             out_valid,
  output logic             word_done,
  output logic             overflw,
  output logic             aborted,
  output logic [CNT_W-1:0] ovf_count,
  output logic             alarm
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  sa_state_t     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;

  logic take, last, abort, cin, sum, cout, ovf;

  always_comb begin
    take  = in_valid && (start || state_q == RUN);
    last  = take && !start && idx_q == LAST;
    abort = in_valid && start && state_q == RUN;
    // a start bit always begins with a clean carry
    cin   = start ? 1'b0 : carry_q;
    sum   = line1 ^ line2 ^ cin;
    cout  = (line1 & line2) | (line1 & cin) | (line2 & cin);
    if (SIGNED_MODE == MODE_SIGNED)
      ovf = last && (cin ^ cout);
    else
      ovf = last && cout;
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    if (take) begin
      if (last) begin
        state_d = IDLE;
        idx_d   = '0;
        carry_d = 1'b0;
      end else begin
        state_d = RUN;
        idx_d   = start ? IW'(1) : idx_q + 1'b1;
        carry_d = cout;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      outp      <= 1'b0;
      out_valid <= 1'b0;
      word_done <= 1'b0;
      overflw   <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      outp      <= take & sum;
      out_valid <= take;
      word_done <= last;
      overflw   <= ovf;
      aborted   <= abort;
    end
  end

  ovf_stat_counter #(
    .CNT_W       (CNT_W),
    .ALARM_THRESH(ALARM_THRESH)
  ) u_stat (
    .clk    (clock),
    .rst_n  (reset_n),
    .inc_i  (ovf),
    .clr_i  (clear_stat),
    .count_o(ovf_count),
    .alarm_o(alarm)
  );

  a_frame: assert property (@(posedge clock) disable iff (!reset_n)
    !(!out_valid && (word_done || overflw)));

  a_alarm: assert property (@(posedge clock) disable iff (!reset_n)
    !(alarm && ovf_count < CNT_W'(ALARM_THRESH)));

endmodule
